fault_manager_nch: RTL
======================

Name: fault_manager_nch

Overview:
Parametrised N-channel fault supervisor, the next generation of the fixed four-input (OV/UV/OT/UC) fault FSM. Each channel has per-channel masking, a persistence filter, a saturating event counter and a sticky pending flag. All channels feed one global NORMAL/WARNING/FAULT/SHUTDOWN state machine, with timed auto-recovery from WARNING and a configurable set of shutdown-capable channels. It sits between the analog comparator flags and the power-stage enable logic.

Parameters:
N_CH, 4, number of fault channels (1..16)
CNT_W, 8, width of each event counter
WARN_TH, 4, consecutive effective-fault cycles to qualify a warning (>=1)
FAULT_TH, 16, consecutive effective-fault cycles to escalate (> WARN_TH)
REC_TH, 8, consecutive all-clear cycles for auto-recovery from WARNING (>=1)
SHDN_CH, 4'b1000, N_CH-bit mask of channels whose FAULT_TH escalates to SHUTDOWN
ID_W, $clog2(N_CH+1), width of active_id

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
flt_in  in  N_CH  raw fault flags, bit i = channel i
mask  in  N_CH  1 = ignore channel i
clear  in  1  single-cycle clear request
state  out  2  0 NORMAL, 1 WARNING, 2 FAULT, 3 SHUTDOWN
warn  out  1  state==WARNING
fault  out  1  state==FAULT
shutdown  out  1  state==SHUTDOWN
pend  out  N_CH  sticky per-channel qualified-fault flags
active_id  out  ID_W  lowest-index set pend bit + 1; 0 = none
cnt_flat  out  N_CH*CNT_W  event counters, channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (async assert, sync release): all registers and outputs are 0; state=NORMAL.
- eff[i] = flt_in[i] & ~mask[i], evaluated combinationally each cycle.
- Persistence counter pc[i], width clog2(FAULT_TH+1):
  - If eff[i]=1: increments, saturating at FAULT_TH.
  - If eff[i]=0: clears to 0.
  - Masking a channel mid-persistence clears pc[i] on the next edge; pend[i] is kept.
- Qualify event: the edge where pc[i] goes WARN_TH-1 -> WARN_TH. On that edge:
  - pend[i] <= 1.
  - cnt[i] increments, saturating at 2^CNT_W-1. Counters clear only on rst.
- pend[i] clears on a clear cycle only if eff[i]=0 and state!=SHUTDOWN. If qualify and clear coincide on a channel, set wins.
- FSM transitions use registered pc values, so each transition lands one edge after the threshold is reached.
  - NORMAL -> WARNING: any pc[i] >= WARN_TH.
  - WARNING/FAULT -> SHUTDOWN: any pc[i]==FAULT_TH with SHDN_CH[i]=1.
  - WARNING -> FAULT: any pc[i]==FAULT_TH with SHDN_CH[i]=0.
  - WARNING -> NORMAL:
    - rc==REC_TH, where rc counts consecutive cycles with eff==0 and clears on any eff bit or on leaving WARNING; or
    - clear=1 with eff==0.
  - FAULT -> NORMAL: only clear=1 with eff==0. There is no auto-recovery from FAULT.
  - SHUTDOWN: terminal; clear is ignored; only rst exits.
- Same-cycle priority: SHUTDOWN > FAULT > WARNING entry > clear > auto-recovery.
- Output timing:
  - warn, fault and shutdown are registered from next-state and change on the same edge as state.
  - active_id is registered from next pend.
- Timeline for one channel held high from edge 1:
  - pc reaches WARN_TH at edge WARN_TH.
  - WARNING at edge WARN_TH+1.
  - FAULT or SHUTDOWN at edge FAULT_TH+1.
- Mid-operation rst forces all outputs to 0 immediately, with no clock needed.

Test Plan:
1. Defaults; flt_in[3]=1 for 3 cycles -> state stays 0; cnt all 0; pend=0000; active_id=0.
2. flt_in[0]=1 for 10 cycles, then 0 ->
   - WARNING at edge 5; cnt0=1; pend=0001; active_id=1.
   - NORMAL 8 clean cycles after release; pend stays 0001.
   - clear pulse -> pend=0000, active_id=0.
3. flt_in[1]=1 for 20 cycles ->
   - WARNING at edge 5, FAULT at edge 17; fault=1.
   - After release, state holds FAULT for 50 cycles.
   - clear with flt_in=0 -> NORMAL next edge.
   - Repeat clear while flt_in[1]=1 -> stays FAULT.
4. flt_in[3]=1 for 20 cycles -> SHUTDOWN at edge 17; clear ignored; pend stays 1000; rst -> all outputs 0.
5. Masking and priority:
   - mask[2]=1, flt_in[2]=1 for 100 cycles -> no state or counter change.
   - Unmask, then assert ch0 and ch2 together -> pend=0101, active_id=1.
   - With CNT_W=2, six qualified ch0 episodes -> cnt0=3 (saturated).
6. Async rst pulsed between clock edges while in FAULT -> state=0, fault=0, pend=0 before the next edge; first qualified event after release behaves as in scenario 2.

Source files
------------

// File: rtl/fault_manager_nch.sv
// N-channel fault supervisor: per-channel mask, persistence filter, saturating event
// counter and sticky pending flag feeding one NORMAL/WARNING/FAULT/SHUTDOWN state machine.
module fault_manager_nch #(
    parameter int              N_CH     = 4,
    parameter int              CNT_W    = 8,
    parameter int              WARN_TH  = 4,
    parameter int              FAULT_TH = 16,
    parameter int              REC_TH   = 8,
    parameter logic [N_CH-1:0] SHDN_CH  = N_CH'(4'b1000),
    parameter int              ID_W     = $clog2(N_CH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       flt_in,
    input  logic [N_CH-1:0]       mask,
    input  logic                  clear,
    output logic [1:0]            state,
    output logic                  warn,
    output logic                  fault,
    output logic                  shutdown,
    output logic [N_CH-1:0]       pend,
    output logic [ID_W-1:0]       active_id,
    output logic [N_CH*CNT_W-1:0] cnt_flat
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_WARNING  = 2'd1,
        ST_FAULT    = 2'd2,
        ST_SHUTDOWN = 2'd3
    } state_e;

    localparam int PC_W = $clog2(FAULT_TH + 1);
    localparam int RC_W = $clog2(REC_TH + 1);
    localparam logic [PC_W-1:0]  PC_QUAL  = PC_W'(WARN_TH - 1);
    localparam logic [PC_W-1:0]  PC_WARN  = PC_W'(WARN_TH);
    localparam logic [PC_W-1:0]  PC_FAULT = PC_W'(FAULT_TH);
    localparam logic [RC_W-1:0]  RC_DONE  = RC_W'(REC_TH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [N_CH-1:0]  eff_s;
    logic [N_CH-1:0]  qual_s;
    logic [N_CH-1:0]  warn_hit_s;
    logic [N_CH-1:0]  fault_hit_s;
    logic             any_warn_s;
    logic             any_flt_s;
    logic             any_shdn_s;
    logic             clr_ok_s;

    logic [PC_W-1:0]  pc_q  [N_CH];
    logic [PC_W-1:0]  pc_d  [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    state_e           state_q, state_d;
    logic             warn_q, fault_q, shdn_q;
    logic [ID_W-1:0]  id_q;

    function automatic logic [ID_W-1:0] first_pend(input logic [N_CH-1:0] p);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (p[i]) begin
                id = ID_W'(i + 1);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    assign eff_s = flt_in & ~mask;

    // Per-channel persistence filter, qualify detection, event counter and sticky flag.
    always_comb begin
        qual_s      = '0;
        warn_hit_s  = '0;
        fault_hit_s = '0;
        pend_d      = pend_q;
        for (int i = 0; i < N_CH; i++) begin
            pc_d[i]  = pc_q[i];
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < N_CH; i++) begin
            qual_s[i]      = eff_s[i] && (pc_q[i] == PC_QUAL);
            warn_hit_s[i]  = (pc_q[i] >= PC_WARN);
            fault_hit_s[i] = (pc_q[i] == PC_FAULT);
            if (!eff_s[i]) begin
                pc_d[i] = '0;
            end else if (pc_q[i] == PC_FAULT) begin
                pc_d[i] = pc_q[i];
            end else begin
                pc_d[i] = pc_q[i] + PC_W'(1);
            end
            if (qual_s[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            // A qualify on the same edge as a clear keeps the flag set.
            if (qual_s[i]) begin
                pend_d[i] = 1'b1;
            end else if (clear && !eff_s[i] && (state_q != ST_SHUTDOWN)) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    assign any_warn_s = |warn_hit_s;
    assign any_shdn_s = |(fault_hit_s & SHDN_CH);
    assign any_flt_s  = |(fault_hit_s & ~SHDN_CH);
    assign clr_ok_s   = clear && (eff_s == '0);

    // Global supervisor next-state and recovery counter.
    always_comb begin
        state_d = state_q;
        rc_d    = '0;
        case (state_q)
            ST_NORMAL: begin
                if (any_warn_s) begin
                    state_d = ST_WARNING;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            ST_WARNING: begin
                if (any_shdn_s) begin
                    state_d = ST_SHUTDOWN;
                end else if (any_flt_s) begin
                    state_d = ST_FAULT;
                end else if (clr_ok_s) begin
                    state_d = ST_NORMAL;
                end else if (rc_q == RC_DONE) begin
                    state_d = ST_NORMAL;
                end else begin
                    state_d = ST_WARNING;
                end
            end
            ST_FAULT: begin
                if (any_shdn_s) begin
                    state_d = ST_SHUTDOWN;
                end else if (clr_ok_s) begin
                    state_d = ST_NORMAL;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_SHUTDOWN: begin
                state_d = ST_SHUTDOWN;
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
        // rc only runs while the machine stays in WARNING with every channel clear.
        if ((state_q == ST_WARNING) && (state_d == ST_WARNING) && (eff_s == '0)) begin
            if (rc_q == RC_DONE) begin
                rc_d = rc_q;
            end else begin
                rc_d = rc_q + RC_W'(1);
            end
        end else begin
            rc_d = '0;
        end
    end

    // State, channel and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            rc_q    <= '0;
            pend_q  <= '0;
            warn_q  <= 1'b0;
            fault_q <= 1'b0;
            shdn_q  <= 1'b0;
            id_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                pc_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            pend_q  <= pend_d;
            warn_q  <= (state_d == ST_WARNING);
            fault_q <= (state_d == ST_FAULT);
            shdn_q  <= (state_d == ST_SHUTDOWN);
            id_q    <= first_pend(pend_d);
            for (int i = 0; i < N_CH; i++) begin
                pc_q[i]  <= pc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten the event counters onto the output bus.
    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign state     = state_q;
    assign warn      = warn_q;
    assign fault     = fault_q;
    assign shutdown  = shdn_q;
    assign pend      = pend_q;
    assign active_id = id_q;

endmodule
